// File: rtl/picorv32.sv
// picorv32: compact multi-cycle RV32I core with one shared memory port.
// FETCH -> EXEC -> (MEM ->) FETCH; illegal or misaligned ops park in TRAP.
module picorv32 #(
    parameter int unsigned ENABLE_MUL     = 0,
    parameter int unsigned ENABLE_DIV     = 0,
    parameter int unsigned COMPRESSED_ISA = 0,
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        trap
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, TRAP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [1:0]  ls_lo;
    logic [31:0] regs [0:31];

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign f3     = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign f7     = insn[31:25];

    logic [31:0] rs1v, rs2v;
    assign rs1v = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2v = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7],
                    insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'd0};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12],
                    insn[20], insn[30:21], 1'b0};

    logic is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic is_load, is_store, is_opimm, is_op;
    assign is_lui   = opcode == 7'b0110111;
    assign is_auipc = opcode == 7'b0010111;
    assign is_jal   = opcode == 7'b1101111;
    assign is_jalr  = opcode == 7'b1100111;
    assign is_br    = opcode == 7'b1100011;
    assign is_load  = opcode == 7'b0000011;
    assign is_store = opcode == 7'b0100011;
    assign is_opimm = opcode == 7'b0010011;
    assign is_op    = opcode == 7'b0110011;

    logic legal;
    always_comb begin
        legal = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111: legal = 1'b1;
            7'b1100111: legal = f3 == 3'd0;
            7'b1100011: legal = f3[2:1] != 2'b01;
            7'b0000011: legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            7'b0100011: legal = f3 inside {3'd0, 3'd1, 3'd2};
            7'b0010011: legal = (f3 == 3'd1) ? f7 == 7'h00 :
                                (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) :
                                1'b1;
            7'b0110011: legal = f7 == 7'h00 ||
                                (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            7'b0001111: legal = f3[2:1] == 2'b00;
            default:    legal = 1'b0;
        endcase
    end

    logic [31:0] alu_b, alu_y;
    logic [4:0]  shamt;
    always_comb begin
        alu_b = is_op ? rs2v : imm_i;
        shamt = alu_b[4:0];
        alu_y = '0;
        case (f3)
            3'd0: alu_y = (is_op && f7[5]) ? rs1v - alu_b : rs1v + alu_b;
            3'd1: alu_y = rs1v << shamt;
            3'd2: alu_y = {31'd0, $signed(rs1v) < $signed(alu_b)};
            3'd3: alu_y = {31'd0, rs1v < alu_b};
            3'd4: alu_y = rs1v ^ alu_b;
            3'd5: alu_y = f7[5] ? 32'($signed(rs1v) >>> shamt) : rs1v >> shamt;
            3'd6: alu_y = rs1v | alu_b;
            default: alu_y = rs1v & alu_b;
        endcase
    end

    logic br_cond;
    always_comb begin
        br_cond = 1'b0;
        case (f3)
            3'd0: br_cond = rs1v == rs2v;
            3'd1: br_cond = rs1v != rs2v;
            3'd4: br_cond = $signed(rs1v) < $signed(rs2v);
            3'd5: br_cond = $signed(rs1v) >= $signed(rs2v);
            3'd6: br_cond = rs1v < rs2v;
            3'd7: br_cond = rs1v >= rs2v;
            default: br_cond = 1'b0;
        endcase
    end

    logic        jump, ls_mis, ex_mem, ex_trap;
    logic [31:0] target, npc, ls_addr, st_data;
    logic [3:0]  st_strb;
    assign jump    = is_jal | is_jalr | (is_br & br_cond);
    assign target  = is_jal  ? pc + imm_j :
                     is_jalr ? (rs1v + imm_i) & ~32'd1 : pc + imm_b;
    assign npc     = jump ? target : pc + 32'd4;
    assign ls_addr = rs1v + (is_store ? imm_s : imm_i);
    assign ls_mis  = (f3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00) ||
                     (f3[1:0] == 2'b01 && ls_addr[0]);
    assign ex_mem  = is_load | is_store;
    assign ex_trap = !legal || (jump && target[1:0] != 2'b00) ||
                     (ex_mem && ls_mis);

    always_comb begin
        st_data = rs2v;
        st_strb = 4'b1111;
        case (f3[1:0])
            2'b00: begin
                st_data = {4{rs2v[7:0]}};
                st_strb = 4'b0001 << ls_addr[1:0];
            end
            2'b01: begin
                st_data = {2{rs2v[15:0]}};
                st_strb = ls_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    logic [31:0] ld_sh, ld_data;
    assign ld_sh = mem_rdata >> {ls_lo, 3'b000};
    always_comb begin
        case (f3)
            3'd0:    ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'd1:    ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'd4:    ld_data = {24'd0, ld_sh[7:0]};
            3'd5:    ld_data = {16'd0, ld_sh[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    logic        rf_we;
    logic [31:0] rf_wd;
    always_comb begin
        rf_we = 1'b0;
        rf_wd = alu_y;
        if (state == EXEC && !ex_trap && !ex_mem) begin
            rf_we = is_lui | is_auipc | is_jal | is_jalr | is_op | is_opimm;
            if (is_lui)
                rf_wd = imm_u;
            else if (is_auipc)
                rf_wd = pc + imm_u;
            else if (is_jal || is_jalr)
                rf_wd = pc + 32'd4;
        end else if (state == MEM && mem_ready && is_load) begin
            rf_we = 1'b1;
            rf_wd = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0)
            regs[rd] <= rf_wd;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= FETCH;
            pc        <= PROGADDR_RESET;
            insn      <= '0;
            ls_lo     <= '0;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            trap      <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!mem_valid) begin
                        mem_valid <= 1'b1;
                        mem_instr <= 1'b1;
                        mem_addr  <= {pc[31:2], 2'b00};
                        mem_wstrb <= 4'd0;
                    end else if (mem_ready) begin
                        insn      <= mem_rdata;
                        mem_valid <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (ex_trap) begin
                        trap  <= 1'b1;
                        state <= TRAP;
                    end else if (ex_mem) begin
                        mem_valid <= 1'b1;
                        mem_instr <= 1'b0;
                        mem_addr  <= {ls_addr[31:2], 2'b00};
                        mem_wdata <= st_data;
                        mem_wstrb <= is_store ? st_strb : 4'd0;
                        ls_lo     <= ls_addr[1:0];
                        state     <= MEM;
                    end else begin
                        // next fetch issues straight out of EXEC
                        pc        <= npc;
                        mem_valid <= 1'b1;
                        mem_instr <= 1'b1;
                        mem_addr  <= {npc[31:2], 2'b00};
                        mem_wstrb <= 4'd0;
                        state     <= FETCH;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        pc        <= pc + 32'd4;
                        state     <= FETCH;
                    end
                end
                TRAP: begin
                    mem_valid <= 1'b0;
                    trap      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_picorv32.sv
// Directed bench for picorv32: word RAM responder with optional wait
// states, store/load logging and hand-computed expectations.
module tb_picorv32;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid, mem_instr, trap;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [3:0]  mem_wstrb;

    picorv32 #(.PROGADDR_RESET(32'h0000_0000)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .trap(trap)
    );

    initial forever #5 clk = ~clk;

    localparam logic [6:0] OPIMM = 7'h13;
    localparam logic [6:0] LOAD  = 7'h03;

    logic [31:0] ram [0:255];
    int vectors = 0;
    int fails = 0;
    int max_wait = 0;
    bit hold = 1'b0;
    bit pend = 1'b0;
    int wcnt = 0;
    int stab_err = 0;
    int vcnt = 0;
    bit seen = 1'b0;
    logic [31:0] first_addr;
    logic        first_instr;
    logic [3:0]  first_wstrb;
    logic [31:0] st_addr [0:63];
    logic [31:0] st_data [0:63];
    logic [3:0]  st_strb [0:63];
    logic [31:0] ld_addr [0:63];
    int st_cnt = 0;
    int ld_cnt = 0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    logic        p_instr;
    logic [7:0]  idx;

    function automatic logic [31:0] i_t(input logic [31:0] imm,
        input logic [31:0] rs1, input logic [31:0] f3,
        input logic [31:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] s_t(input logic [31:0] imm,
        input logic [31:0] rs2, input logic [31:0] rs1,
        input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_t(input logic [31:0] imm,
        input logic [31:0] rs2, input logic [31:0] rs1,
        input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] j_t(input logic [31:0] imm,
        input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] r_t(input logic [31:0] f7,
        input logic [31:0] rs2, input logic [31:0] rs1,
        input logic [31:0] f3, input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    // memory responder: random wait states, logs every data access
    initial begin
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_valid) vcnt++;
            if (resetn && mem_valid) begin
                if (!pend) begin
                    pend = 1'b1;
                    p_addr = mem_addr; p_wdata = mem_wdata;
                    p_wstrb = mem_wstrb; p_instr = mem_instr;
                    wcnt = (max_wait == 0) ? 0 :
                           int'($urandom_range(max_wait, 0));
                    if (!seen) begin
                        seen = 1'b1;
                        first_addr = mem_addr;
                        first_instr = mem_instr;
                        first_wstrb = mem_wstrb;
                    end
                end else if (mem_addr !== p_addr || mem_wdata !== p_wdata ||
                             mem_wstrb !== p_wstrb || mem_instr !== p_instr)
                    stab_err++;
                if (hold && !mem_instr) begin
                end else if (wcnt > 0) begin
                    wcnt--;
                end else begin
                    idx = mem_addr[9:2];
                    if (mem_wstrb == 4'd0) begin
                        mem_rdata = ram[idx];
                        if (!mem_instr && ld_cnt < 64) begin
                            ld_addr[ld_cnt] = mem_addr;
                            ld_cnt++;
                        end
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b])
                                ram[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                        if (st_cnt < 64) begin
                            st_addr[st_cnt] = mem_addr;
                            st_data[st_cnt] = mem_wdata;
                            st_strb[st_cnt] = mem_wstrb;
                            st_cnt++;
                        end
                    end
                    mem_ready = 1'b1;
                    pend = 1'b0;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        seen = 1'b0; st_cnt = 0; ld_cnt = 0; vcnt = 0; stab_err = 0;
        for (int i = 0; i < 64; i++) begin
            st_addr[i] = 'x; st_data[i] = 'x;
            st_strb[i] = 'x; ld_addr[i] = 'x;
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    endtask

    task automatic load_counter();
        ram[0] = 32'h3fc00093; ram[1] = 32'h0000a023;
        ram[2] = 32'h0000a103; ram[3] = 32'h00110113;
        ram[4] = 32'h0020a023; ram[5] = 32'hff5ff06f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 resetn = 1'b0;
        clear_logs();
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_instr", 32'(mem_instr), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        resetn = 1'b1;
    endtask

    task automatic wait_stores(input int n, input int budget, input string tag);
        int c = 0;
        while (st_cnt < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(st_cnt >= n), 32'd1);
    endtask

    task automatic wait_trap(input int budget, input string tag);
        int c = 0;
        while (!trap && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(trap), 32'd1);
    endtask

    task automatic check_counter(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), st_addr[i], 32'h3FC);
            check($sformatf("%s_data%0d", tag, i), st_data[i], 32'(i));
            check($sformatf("%s_strb%0d", tag, i), 32'(st_strb[i]), 32'hF);
        end
    endtask

    initial begin
        int c;
        bit found;

        // counter program, zero wait states
        clear_ram();
        load_counter();
        do_reset();
        wait_stores(5, 400, "cnt_progress");
        check("first_addr", first_addr, 32'd0);
        check("first_instr", 32'(first_instr), 32'd1);
        check("first_wstrb", 32'(first_wstrb), 32'd0);
        check_counter("cnt", 5);
        check("cnt_ld_addr", ld_addr[0], 32'h3FC);
        check("cnt_stable", 32'(stab_err), 32'd0);

        // byte / half store lanes
        clear_ram();
        ram[0] = i_t(32'hA5, 0, 0, 5, OPIMM);
        ram[1] = s_t(32'h3FD, 5, 0, 0);
        ram[2] = s_t(32'h3FE, 5, 0, 1);
        ram[3] = j_t(0, 0);
        do_reset();
        wait_stores(2, 200, "lane_progress");
        check("sb_addr", st_addr[0], 32'h3FC);
        check("sb_strb", 32'(st_strb[0]), 32'h2);
        check("sb_data", st_data[0], 32'hA5A5A5A5);
        check("sh_addr", st_addr[1], 32'h3FC);
        check("sh_strb", 32'(st_strb[1]), 32'hC);
        check("sh_data", st_data[1], 32'h00A500A5);
        check("lane_word", ram[255], 32'h00A5A500);

        // load sign / zero extension
        clear_ram();
        ram[64] = 32'h0000_8000;
        ram[0] = i_t(32'h101, 0, 0, 6, LOAD);
        ram[1] = s_t(32'h200, 6, 0, 2);
        ram[2] = i_t(32'h101, 0, 4, 6, LOAD);
        ram[3] = s_t(32'h204, 6, 0, 2);
        ram[4] = i_t(32'h100, 0, 1, 6, LOAD);
        ram[5] = s_t(32'h208, 6, 0, 2);
        ram[6] = i_t(32'h100, 0, 5, 6, LOAD);
        ram[7] = s_t(32'h20C, 6, 0, 2);
        ram[8] = j_t(0, 0);
        do_reset();
        wait_stores(4, 300, "ld_progress");
        check("lb", ram[128], 32'hFFFFFF80);
        check("lbu", ram[129], 32'h00000080);
        check("lh", ram[130], 32'hFFFF8000);
        check("lhu", ram[131], 32'h00008000);
        check("lb_ld_addr", ld_addr[0], 32'h100);

        // branches, jumps and a few ALU ops
        clear_ram();
        ram[0]  = i_t(32'hFFFFFFFF, 0, 0, 1, OPIMM);
        ram[1]  = i_t(1, 0, 0, 2, OPIMM);
        ram[2]  = i_t(32'h33, 0, 0, 3, OPIMM);
        ram[3]  = b_t(8, 0, 0, 0);
        ram[4]  = i_t(32'h55, 0, 0, 3, OPIMM);
        ram[5]  = s_t(32'h200, 3, 0, 2);
        ram[6]  = j_t(12, 1);
        ram[7]  = i_t(32'h66, 0, 0, 1, OPIMM);
        ram[8]  = i_t(32'h77, 0, 0, 1, OPIMM);
        ram[9]  = s_t(32'h204, 1, 0, 2);
        ram[10] = i_t(32'hFFFFFFFF, 0, 0, 1, OPIMM);
        ram[11] = i_t(32'h44, 0, 0, 5, OPIMM);
        ram[12] = b_t(8, 2, 1, 6);
        ram[13] = i_t(1, 5, 0, 5, OPIMM);
        ram[14] = b_t(8, 2, 1, 4);
        ram[15] = i_t(32'h22, 0, 0, 5, OPIMM);
        ram[16] = s_t(32'h208, 5, 0, 2);
        ram[17] = r_t(32'h20, 1, 2, 0, 6);
        ram[18] = s_t(32'h20C, 6, 0, 2);
        ram[19] = i_t(32'h401, 1, 5, 7, OPIMM);
        ram[20] = s_t(32'h210, 7, 0, 2);
        ram[21] = r_t(0, 1, 2, 3, 8);
        ram[22] = s_t(32'h214, 8, 0, 2);
        ram[23] = j_t(0, 0);
        do_reset();
        wait_stores(6, 400, "br_progress");
        check("beq_skip", ram[128], 32'h33);
        check("jal_link", ram[129], 32'h1C);
        check("bltu_blt", ram[130], 32'h45);
        check("sub", ram[131], 32'h2);
        check("srai", ram[132], 32'hFFFFFFFF);
        check("sltu", ram[133], 32'h1);

        // counter program again with 0..5 random wait states
        clear_ram();
        load_counter();
        max_wait = 5;
        do_reset();
        wait_stores(6, 3000, "ws_progress");
        check_counter("ws", 6);
        check("ws_stable", 32'(stab_err), 32'd0);
        max_wait = 0;

        // all-zero instruction word traps
        clear_ram();
        do_reset();
        wait_trap(100, "zero_trap");
        vcnt = 0;
        repeat (100) @(negedge clk);
        check("trap_quiet", 32'(vcnt), 32'd0);
        check("trap_held", 32'(trap), 32'd1);

        // misaligned word store traps without writing
        clear_ram();
        ram[0] = s_t(32'h202, 0, 0, 2);
        do_reset();
        wait_trap(100, "mis_trap");
        repeat (20) @(negedge clk);
        check("mis_nostore", 32'(st_cnt), 32'd0);

        // async reset clears trap immediately
        #2 resetn = 1'b0;
        #1 check("arst_trap", 32'(trap), 32'd0);

        // async reset aborts a stalled data request
        clear_ram();
        load_counter();
        hold = 1'b1;
        clear_logs();
        @(negedge clk);
        resetn = 1'b1;
        c = 0;
        found = 1'b0;
        while (!found && c < 100) begin
            @(negedge clk);
            c++;
            found = mem_valid && !mem_instr;
        end
        check("hold_data_req", 32'(found), 32'd1);
        #2 resetn = 1'b0;
        #1 check("arst_valid", 32'(mem_valid), 32'd0);
        check("arst_nostore", 32'(st_cnt), 32'd0);
        clear_logs();
        hold = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("rerun_seen", 32'(seen), 32'd1);
        check("rerun_addr", first_addr, 32'd0);
        check("rerun_instr", 32'(first_instr), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/picorv32.md
Name: picorv32

Overview:
- Compact multi-cycle RV32I processor core with a single shared native memory port for instruction fetch and data access.
- Sits under the board-level top, which attaches a word-organised RAM (firmware image at address 0) with a one-cycle ready pulse.
- No multiply/divide, no compressed ISA, no CSRs, no interrupts. Any unsupported instruction halts the core via trap.

Parameters:
- ENABLE_MUL, 0, compatibility only. The core is RV32I; a nonzero value is ignored and M-extension opcodes trap.
- ENABLE_DIV, 0, compatibility only. A nonzero value is ignored.
- COMPRESSED_ISA, 0, compatibility only. A nonzero value is ignored; 16-bit encodings trap.
- PROGADDR_RESET, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  out  1  memory request pending
- mem_instr  out  1  request is an instruction fetch
- mem_ready  in  1  request completes at this rising edge
- mem_addr  out  32  word-aligned byte address; bits [1:0] are always 0
- mem_wdata  out  32  store data, lane-replicated
- mem_wstrb  out  4  byte write enables; 0 means read
- mem_rdata  in  32  read word, sampled when mem_ready=1
- trap  out  1  core halted on an exception

Behaviour:
- Reset (resetn=0, asynchronous, takes effect immediately):
  - mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, trap=0.
  - PC=PROGADDR_RESET, FSM=FETCH.
  - Register file contents are undefined except x0.
  - Reset asserted mid-transaction aborts the transaction with no completion.
- FSM states: FETCH -> EXEC -> (MEM ->) FETCH; TRAP is terminal until reset.
- Handshake:
  - While mem_valid=1, mem_addr, mem_wdata, mem_wstrb and mem_instr stay constant until a rising edge with mem_ready=1.
  - mem_valid drops in the cycle after completion. The next request may assert in that same following cycle at the earliest.
  - mem_ready while mem_valid=0 is ignored.
  - Any number of wait states is allowed.
- FETCH: mem_valid=1, mem_instr=1, mem_wstrb=0, mem_addr=PC. The instruction word is latched on completion.
- EXEC (one cycle): decode, register read, ALU, branch resolution.
  - Non-memory instructions write rd and update PC here.
  - Next-instruction latency is fetch handshake + 1 cycle.
- MEM:
  - Loads/stores issue mem_valid=1, mem_instr=0, mem_addr={addr[31:2],2'b00}.
  - Loads write rd on completion; PC+4 follows.
- Store lanes:
  - SB: wstrb=4'b0001<<addr[1:0]; wdata=byte replicated x4.
  - SH: wstrb=0011 (addr[1]=0) or 1100 (addr[1]=1); wdata=half replicated x2.
  - SW: wstrb=1111.
- Load lanes: LB/LBU/LH/LHU select a byte or half from mem_rdata by addr[1:0], then sign- or zero-extend to 32 bits.
- Supported instructions: LUI, AUIPC, JAL, JALR (target bit0 cleared), BEQ/BNE/BLT/BGE/BLTU/BGEU, loads, stores, all OP-IMM and OP.
  - Shifts are single-cycle barrel shifts; shift amount is rs2[4:0] or shamt.
  - FENCE and FENCE.I execute as NOP.
- Arithmetic: all 32-bit, modulo 2^32. SLT/SLTI use signed compare; SLTU/SLTIU use unsigned compare. x0 always reads 0 and writes to it are discarded.
- Trap conditions, entering TRAP with trap=1, mem_valid=0 and no further requests:
  - Illegal or unsupported opcode, including all-zero and all-ones words.
  - ECALL, EBREAK, or any SYSTEM/CSR instruction.
  - Misaligned load/store: word with addr[1:0]≠0, or half with addr[0]≠0.
  - Taken jump/branch target with bits [1:0]≠0.
- A trapping instruction produces no register write or memory write.

Test Plan:
- Counter program at address 0: 3fc00093, 0000a023, 0000a103, 00110113, 0020a023, ff5ff06f.
  - Expected: first request is addr 0, mem_instr=1, wstrb=0.
  - Then a store to 0x3FC with wstrb=F and wdata=0.
  - Subsequent stores to 0x3FC carry wdata 1, 2, 3, … and loads read 0x3FC with wstrb=0.
- Byte/half lanes: x5=0xA5, sb x5,0x3FD(x0) -> addr 0x3FC, wstrb=0010, wdata=A5A5A5A5. Then sh to 0x3FE -> wstrb=1100.
- Sign extension: memory word 0x0000_8000 at 0x100.
  - lb x6,0x101(x0) -> x6=FFFFFF80.
  - lbu -> 0x80.
  - lh from 0x100 -> FFFF8000.
  - Results checked by storing each to RAM.
- Branch/jump:
  - beq x0,x0,+8 skips the next instruction.
  - jal x1,+12 gives x1=PC+4.
  - bltu with 0xFFFFFFFF vs 1 is not taken; blt with the same operands is taken.
- Wait states: mem_ready delayed 0 to 5 cycles randomly -> addr/wdata/wstrb stay stable while valid, and the counter program results match the zero-wait case.
- Trap and reset:
  - Fetching word 00000000 -> trap=1, mem_valid stays 0 for 100 cycles.
  - Pulling resetn low mid-request drops mem_valid and trap immediately.
  - After release, the next request fetches PROGADDR_RESET.
